// File: rtl/prbs_chk_par_if.sv
// Lane-side bus of the parallel PRBS checker: stream in, lock/error/counter status out.
interface prbs_chk_par_if #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned BIT_CNT_WIDTH = 32,
    parameter int unsigned ERR_CNT_WIDTH = 32
);
    logic [2:0]               prbs_sel;
    logic                     clr;
    logic                     din_vld;
    logic [DATA_W-1:0]        din;
    logic                     locked;
    logic                     err_vld;
    logic [DATA_W-1:0]        err_vec;
    logic                     err_word;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;
    logic                     bit_cnt_full;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;
    logic                     err_cnt_full;
    logic                     lock_loss;

    modport master (
        output prbs_sel, clr, din_vld, din,
        input  locked, err_vld, err_vec, err_word, bit_cnt, bit_cnt_full,
               err_cnt, err_cnt_full, lock_loss
    );

    modport slave (
        input  prbs_sel, clr, din_vld, din,
        output locked, err_vld, err_vec, err_word, bit_cnt, bit_cnt_full,
               err_cnt, err_cnt_full, lock_loss
    );
endinterface

// File: rtl/prbs_chk_par.sv
// Parallel-word PRBS checker: self-syncs in HUNT, free-runs in LOCK, reports per-bit
// mismatches and saturating checked-bit / bit-error counters.
module prbs_chk_par #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned BIT_CNT_WIDTH = 32,
    parameter int unsigned ERR_CNT_WIDTH = 32,
    parameter int unsigned LOCK_CNT      = 4,
    parameter int unsigned LOSS_CNT      = 4
) (
    input  logic           clk,
    input  logic           rst,
    prbs_chk_par_if.slave  bus
);
    localparam int unsigned SW  = 31;
    localparam int unsigned PW  = $clog2(DATA_W + 1);
    localparam int unsigned GW  = $clog2(LOCK_CNT + 1);
    localparam int unsigned LW  = $clog2(LOSS_CNT + 1);
    localparam int unsigned BSW = BIT_CNT_WIDTH + 6;
    localparam int unsigned ESW = ERR_CNT_WIDTH + 6;
    localparam logic [BSW-1:0] BMAX = BSW'({BIT_CNT_WIDTH{1'b1}});
    localparam logic [ESW-1:0] EMAX = ESW'({ERR_CNT_WIDTH{1'b1}});

    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]               fsm_q, fsm_d;
    logic [SW-1:0]            lfsr_q, lfsr_d;
    logic [2:0]               sel_q, sel_d;
    logic [GW-1:0]            good_q, good_d;
    logic [LW-1:0]            bad_q, bad_d;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     bit_full_q, bit_full_d;
    logic                     err_full_q, err_full_d;
    logic                     err_vld_q, err_vld_d;
    logic [DATA_W-1:0]        err_vec_q, err_vec_d;
    logic                     err_word_q, err_word_d;
    logic                     lock_loss_q, lock_loss_d;

    logic [DATA_W-1:0]        pred_c;
    logic [DATA_W-1:0]        err_c;
    logic [SW-1:0]            pred_st_c;
    logic [SW-1:0]            hunt_st_c;
    logic [PW-1:0]            ones_c;
    logic [BSW-1:0]           bsum_c;
    logic [ESW-1:0]           esum_c;

    // Feedback bit; s[0] is the most recent bit, s[k] the bit k+1 steps ago.
    function automatic logic fb(input logic [SW-1:0] s, input logic [2:0] sel);
        case (sel)
            3'd1:    fb = s[8]  ^ s[4];
            3'd2:    fb = s[14] ^ s[13];
            3'd3:    fb = s[22] ^ s[17];
            3'd4:    fb = s[30] ^ s[27];
            default: fb = s[6]  ^ s[5];
        endcase
    endfunction

    function automatic logic [SW-1:0] sel_mask(input logic [2:0] sel);
        case (sel)
            3'd1:    sel_mask = 31'h0000_01FF;
            3'd2:    sel_mask = 31'h0000_7FFF;
            3'd3:    sel_mask = 31'h007F_FFFF;
            3'd4:    sel_mask = 31'h7FFF_FFFF;
            default: sel_mask = 31'h0000_007F;
        endcase
    endfunction

    // Unrolled prediction from state, plus the self-sync reload from received bits.
    always_comb begin
        pred_c    = '0;
        pred_st_c = lfsr_q;
        hunt_st_c = lfsr_q;
        ones_c    = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            pred_c[i] = fb(pred_st_c, sel_q);
            pred_st_c = {pred_st_c[SW-2:0], pred_c[i]};
            hunt_st_c = {hunt_st_c[SW-2:0], bus.din[i]};
        end
        err_c = bus.din ^ pred_c;
        for (int i = 0; i < DATA_W; i++) begin
            ones_c = ones_c + PW'(err_c[i]);
        end
    end

    // Next-state: FSM, LFSR state, run counters, status counters, outputs.
    always_comb begin
        fsm_d       = fsm_q;
        lfsr_d      = lfsr_q;
        sel_d       = bus.prbs_sel;
        good_d      = good_q;
        bad_d       = bad_q;
        bit_cnt_d   = bit_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_vld_d   = 1'b0;
        err_vec_d   = err_vec_q;
        err_word_d  = 1'b0;
        lock_loss_d = 1'b0;
        bsum_c      = BSW'(bit_cnt_q) + BSW'(DATA_W);
        esum_c      = ESW'(err_cnt_q) + ESW'(ones_c);

        if (bus.din_vld) begin
            err_vld_d  = 1'b1;
            err_vec_d  = err_c;
            err_word_d = |err_c;
        end

        if (bus.prbs_sel != sel_q) begin
            // A new polynomial invalidates any sync achieved so far.
            fsm_d       = ST_HUNT;
            lfsr_d      = '0;
            good_d      = '0;
            bad_d       = '0;
            lock_loss_d = (fsm_q == ST_LOCK);
        end else if (bus.din_vld) begin
            case (fsm_q)
                ST_HUNT: begin
                    lfsr_d = hunt_st_c;
                    if (!(|err_c) && |(lfsr_q & sel_mask(sel_q))) begin
                        if (good_q == GW'(LOCK_CNT - 1)) begin
                            fsm_d  = ST_LOCK;
                            good_d = '0;
                            bad_d  = '0;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                default: begin
                    lfsr_d    = pred_st_c;
                    bit_cnt_d = (bsum_c > BMAX) ? '1 : bsum_c[BIT_CNT_WIDTH-1:0];
                    err_cnt_d = (esum_c > EMAX) ? '1 : esum_c[ERR_CNT_WIDTH-1:0];
                    if (|err_c) begin
                        if (bad_q == LW'(LOSS_CNT - 1)) begin
                            fsm_d       = ST_HUNT;
                            lock_loss_d = 1'b1;
                            good_d      = '0;
                            bad_d       = '0;
                        end else begin
                            bad_d = bad_q + LW'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
            endcase
        end

        if (bus.clr) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
        bit_full_d = (bit_cnt_d == {BIT_CNT_WIDTH{1'b1}});
        err_full_d = (err_cnt_d == {ERR_CNT_WIDTH{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_HUNT;
            lfsr_q      <= '0;
            sel_q       <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
            bit_full_q  <= 1'b0;
            err_full_q  <= 1'b0;
            err_vld_q   <= 1'b0;
            err_vec_q   <= '0;
            err_word_q  <= 1'b0;
            lock_loss_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            lfsr_q      <= lfsr_d;
            sel_q       <= sel_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
            bit_full_q  <= bit_full_d;
            err_full_q  <= err_full_d;
            err_vld_q   <= err_vld_d;
            err_vec_q   <= err_vec_d;
            err_word_q  <= err_word_d;
            lock_loss_q <= lock_loss_d;
        end
    end

    assign bus.locked       = (fsm_q == ST_LOCK);
    assign bus.err_vld      = err_vld_q;
    assign bus.err_vec      = err_vec_q;
    assign bus.err_word     = err_word_q;
    assign bus.bit_cnt      = bit_cnt_q;
    assign bus.bit_cnt_full = bit_full_q;
    assign bus.err_cnt      = err_cnt_q;
    assign bus.err_cnt_full = err_full_q;
    assign bus.lock_loss    = lock_loss_q;

endmodule

// File: tb/tb_prbs_chk_par.sv
// Directed bench for prbs_chk_par: lock, single-bit error, loss/relock, saturation,
// clr priority, gapped input, all-zero input and polynomial switching.
module tb_prbs_chk_par;
    localparam int unsigned DW = 8;
    localparam int unsigned BCW = 8;
    localparam int unsigned ECW = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    logic [30:0] g_s;
    logic [2:0]  cur_sel;
    logic [7:0]  w;

    always #5 clk = ~clk;

    prbs_chk_par_if #(.DATA_W(DW), .BIT_CNT_WIDTH(BCW), .ERR_CNT_WIDTH(ECW)) bus_if ();

    prbs_chk_par #(
        .DATA_W(DW), .BIT_CNT_WIDTH(BCW), .ERR_CNT_WIDTH(ECW), .LOCK_CNT(4), .LOSS_CNT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference stream: b[n] = b[n-N] ^ b[n-T], earliest bit placed in w[7].
    task automatic gen_word(output logic [7:0] wo);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            case (cur_sel)
                3'd4:    b = g_s[30] ^ g_s[27];
                default: b = g_s[6] ^ g_s[5];
            endcase
            wo[i] = b;
            g_s = {g_s[29:0], b};
        end
    endtask

    task automatic cyc(input logic vld, input logic [7:0] d);
        bus_if.din_vld = vld;
        bus_if.din = d;
        @(posedge clk);
        #1;
        bus_if.din_vld = 1'b0;
    endtask

    task automatic send(input logic [7:0] flip);
        logic [7:0] x;
        gen_word(x);
        cyc(1'b1, x ^ flip);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 8'h00);
        cyc(1'b0, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        bus_if.prbs_sel = 3'd0;
        bus_if.clr = 1'b0;
        bus_if.din_vld = 1'b0;
        bus_if.din = '0;
        cur_sel = 3'd0;
        do_reset();
        check("rst_locked", 32'(bus_if.locked), 0);
        check("rst_err_vld", 32'(bus_if.err_vld), 0);
        check("rst_err_vec", 32'(bus_if.err_vec), 0);
        check("rst_bit_cnt", 32'(bus_if.bit_cnt), 0);
        check("rst_err_cnt", 32'(bus_if.err_cnt), 0);
        check("rst_lock_loss", 32'(bus_if.lock_loss), 0);
        check("rst_fulls", 32'({bus_if.bit_cnt_full, bus_if.err_cnt_full}), 0);

        // Clean PRBS7: first word only seeds the state, four more good words lock.
        g_s = 31'h1;
        repeat (4) send(8'h00);
        check("lock_early", 32'(bus_if.locked), 0);
        send(8'h00);
        check("lock_5th", 32'(bus_if.locked), 1);
        check("lock_err_vld", 32'(bus_if.err_vld), 1);
        check("lock_err_word", 32'(bus_if.err_word), 0);
        check("lock_bit_cnt", 32'(bus_if.bit_cnt), 0);
        repeat (3) send(8'h00);
        check("clean_bit_cnt", 32'(bus_if.bit_cnt), 24);
        check("clean_err_cnt", 32'(bus_if.err_cnt), 0);

        // Single flipped bit while locked.
        send(8'h08);
        check("flip_err_vec", 32'(bus_if.err_vec), 32'h08);
        check("flip_err_word", 32'(bus_if.err_word), 1);
        check("flip_err_cnt", 32'(bus_if.err_cnt), 1);
        check("flip_locked", 32'(bus_if.locked), 1);
        check("flip_bit_cnt", 32'(bus_if.bit_cnt), 32);
        send(8'h00);
        check("after_flip_vec", 32'(bus_if.err_vec), 0);
        check("after_flip_err_cnt", 32'(bus_if.err_cnt), 1);
        check("after_flip_bit_cnt", 32'(bus_if.bit_cnt), 40);

        // Idle cycle is ignored.
        cyc(1'b0, 8'hFF);
        check("idle_err_vld", 32'(bus_if.err_vld), 0);
        check("idle_bit_cnt", 32'(bus_if.bit_cnt), 40);
        check("idle_err_vec_hold", 32'(bus_if.err_vec), 0);

        // Four errored words drop lock on the fourth.
        repeat (3) send(8'h01);
        check("loss3_locked", 32'(bus_if.locked), 1);
        check("loss3_pulse", 32'(bus_if.lock_loss), 0);
        send(8'h81);
        check("loss4_pulse", 32'(bus_if.lock_loss), 1);
        check("loss4_locked", 32'(bus_if.locked), 0);
        check("loss4_err_cnt", 32'(bus_if.err_cnt), 6);
        check("loss4_bit_cnt", 32'(bus_if.bit_cnt), 72);
        cyc(1'b0, 8'h00);
        check("loss_pulse_end", 32'(bus_if.lock_loss), 0);

        // Checker state stayed aligned, so four clean words relock.
        repeat (3) send(8'h00);
        check("relock_early", 32'(bus_if.locked), 0);
        check("hunt_frozen_cnt", 32'(bus_if.bit_cnt), 72);
        send(8'h00);
        check("relock", 32'(bus_if.locked), 1);

        // Bit counter saturation at 255.
        repeat (22) send(8'h00);
        check("sat_pre_cnt", 32'(bus_if.bit_cnt), 248);
        check("sat_pre_full", 32'(bus_if.bit_cnt_full), 0);
        send(8'h00);
        check("sat_cnt", 32'(bus_if.bit_cnt), 255);
        check("sat_full", 32'(bus_if.bit_cnt_full), 1);
        send(8'h00);
        check("sat_hold", 32'(bus_if.bit_cnt), 255);

        // clr beats a counted word on the same edge.
        bus_if.clr = 1'b1;
        send(8'h10);
        bus_if.clr = 1'b0;
        check("clr_bit_cnt", 32'(bus_if.bit_cnt), 0);
        check("clr_err_cnt", 32'(bus_if.err_cnt), 0);
        check("clr_full", 32'(bus_if.bit_cnt_full), 0);
        check("clr_locked", 32'(bus_if.locked), 1);
        send(8'h00);
        check("post_clr_cnt", 32'(bus_if.bit_cnt), 8);

        // Gapped stream gives the same result as contiguous.
        do_reset();
        g_s = 31'h1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) check("gap_lock_early", 32'(bus_if.locked), 0);
            send(8'h00);
            cyc(1'b0, 8'h00);
        end
        check("gap_locked", 32'(bus_if.locked), 1);
        for (int k = 0; k < 3; k++) begin
            send(8'h00);
            cyc(1'b0, 8'h00);
        end
        check("gap_bit_cnt", 32'(bus_if.bit_cnt), 24);
        check("gap_err_cnt", 32'(bus_if.err_cnt), 0);

        // All-zero input never locks.
        do_reset();
        repeat (10) cyc(1'b1, 8'h00);
        check("zero_locked", 32'(bus_if.locked), 0);
        check("zero_bit_cnt", 32'(bus_if.bit_cnt), 0);

        // PRBS31 locks after sel change, then switching back forces HUNT.
        bus_if.prbs_sel = 3'd4;
        cur_sel = 3'd4;
        cyc(1'b0, 8'h00);
        g_s = 31'h2A5A_1234;
        for (int k = 0; k < 30; k++) begin
            if (bus_if.locked !== 1'b1) send(8'h00);
        end
        check("prbs31_locked", 32'(bus_if.locked), 1);
        send(8'h00);
        check("prbs31_clean", 32'(bus_if.err_vec), 0);
        bus_if.prbs_sel = 3'd0;
        cur_sel = 3'd0;
        cyc(1'b0, 8'h00);
        check("sel_switch_unlock", 32'(bus_if.locked), 0);
        check("sel_switch_pulse", 32'(bus_if.lock_loss), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
